// File: rtl/xreg_wb_ctrl.sv
// Write-back controller for the 16-entry RV32E register file: arbitrates the
// single write port between execute and LSU load returns, and tracks pending loads.
module xreg_wb_ctrl #(
    parameter int XLEN = 32,
    parameter int NREG = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exe_valid,
    output logic            exe_ready,
    input  logic [3:0]      exe_rd,
    input  logic [XLEN-1:0] exe_data,
    input  logic            lsu_issue,
    input  logic [3:0]      lsu_issue_rd,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [3:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            wreq,
    output logic [3:0]      windex,
    output logic [XLEN-1:0] wdata,
    output logic [NREG-1:0] busy,
    output logic            err
);

    typedef enum logic {
        ST_RESET,
        ST_RUN
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            wsrc_lsu;
    logic            lsu_fire;
    logic            exe_fire;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;
    logic [NREG-1:0] busy_d;
    logic            err_issue;
    logic            err_return;

    // lsu_ready stays low for the first cycle after reset is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lsu_ready = 1'b0;
        exe_ready = 1'b0;
        case (state_q)
            ST_RESET: state_d = ST_RUN;
            ST_RUN:   lsu_ready = !rst;
            default:  state_d = ST_RESET;
        endcase
        if (!rst) begin
            exe_ready = !lsu_valid && !((exe_rd != 4'd0) && busy[exe_rd]);
        end
    end

    assign lsu_fire = lsu_valid && lsu_ready;
    assign exe_fire = exe_valid && exe_ready;

    // Scoreboard: a load clears its bit at the edge where its data commits.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (lsu_issue && (lsu_issue_rd != 4'd0)) begin
            set_mask[lsu_issue_rd] = 1'b1;
        end
        if (wreq && wsrc_lsu) begin
            clr_mask[windex] = 1'b1;
        end
        busy_d    = (busy & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;
        err_issue = lsu_issue && (lsu_issue_rd != 4'd0) && busy[lsu_issue_rd]
                    && !clr_mask[lsu_issue_rd];
        err_return = lsu_fire && (lsu_rd != 4'd0) && !busy[lsu_rd];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
            err  <= 1'b0;
        end else begin
            busy <= busy_d;
            if (err_issue || err_return) begin
                err <= 1'b1;
            end
        end
    end

    // Write stage: LSU has fixed priority; x0 targets handshake but never write.
    always_ff @(posedge clk) begin
        if (rst) begin
            wreq     <= 1'b0;
            windex   <= 4'd0;
            wdata    <= '0;
            wsrc_lsu <= 1'b0;
        end else if (lsu_fire) begin
            wreq     <= (lsu_rd != 4'd0);
            wsrc_lsu <= 1'b1;
            if (lsu_rd != 4'd0) begin
                windex <= lsu_rd;
                wdata  <= lsu_data;
            end
        end else if (exe_fire) begin
            wreq     <= (exe_rd != 4'd0);
            wsrc_lsu <= 1'b0;
            if (exe_rd != 4'd0) begin
                windex <= exe_rd;
                wdata  <= exe_data;
            end
        end else begin
            wreq <= 1'b0;
        end
    end

endmodule
